fwd_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS pipeline. It is the producer side of the forwarding-mux interface: it drives the 3-bit select for every forwarding mux in D, E and M, and it drives the pipeline stall. It keeps a shadow scoreboard of the destination, result class and time-to-ready of the instructions in E, M and W. It also runs the busy counter of the multiply/divide unit.

---
 rtl/fwd_ctrl_pkg.sv | 64 ++++++
 rtl/fwd_pick.sv | 50 +++++
 rtl/fwd_ctrl.sv | 146 ++++++++++++++
 tb/tb_fwd_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_ctrl_pkg.sv
// fwd_ctrl_pkg: shared definitions for the MIPS hazard/forwarding controller.
//   - forwarding select codes driven onto every forwarding mux
//   - result-class (src) codes, operand-use (tuse) sentinel, reader stages
//   - multiply/divide opcode classes
//   - shadow scoreboard entry layouts for the E, M and W stages
//   - entry_match(): does a scoreboard entry produce register r
package fwd_ctrl_pkg;

   localparam int tmux_size = 3;

   localparam logic [tmux_size-1:0] FWD_ORI    = 3'd0;
   localparam logic [tmux_size-1:0] FWD_EM_ALU = 3'd1;
   localparam logic [tmux_size-1:0] FWD_MW_ALU = 3'd2;
   localparam logic [tmux_size-1:0] FWD_MW_MD  = 3'd3;
   localparam logic [tmux_size-1:0] FWD_MW_CP0 = 3'd4;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MEM = 2'd1;
   localparam logic [1:0] SRC_MD  = 2'd2;
   localparam logic [1:0] SRC_CP0 = 2'd3;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] STAGE_D = 2'd0;
   localparam logic [1:0] STAGE_E = 2'd1;
   localparam logic [1:0] STAGE_M = 2'd2;

   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MULT = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [4:0] wa;
      logic [1:0] src;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
   } e_entry_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] wa;
      logic [1:0] src;
      logic [1:0] tnew;
      logic [4:0] rt;
   } m_entry_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] wa;
      logic [1:0] src;
   } w_entry_t;

   // Register $0 is hard-wired, so it never matches a producer.
   function automatic logic entry_match(input logic       valid,
                                        input logic [4:0] wa,
                                        input logic [4:0] r);
      return valid && (wa == r) && (r != 5'd0);
   endfunction

endpackage

// File: rtl/fwd_pick.sv
// fwd_pick: forwarding select for one operand reader.
//   reg_i      register read by the consumer
//   stage_i    stage of the consumer (STAGE_D / STAGE_E / STAGE_M)
//   m_*_i      M-stage scoreboard entry (valid, dest, result class, tnew)
//   w_*_i      W-stage scoreboard entry (valid, dest, result class)
//   sel_o      forwarding mux select (FWD_* code)
// D and E readers look at M first, then W; the M reader looks at W only.
module fwd_pick
   import fwd_ctrl_pkg::*;
(
   input  logic [4:0]           reg_i,
   input  logic [1:0]           stage_i,
   input  logic                 m_valid_i,
   input  logic [4:0]           m_wa_i,
   input  logic [1:0]           m_src_i,
   input  logic [1:0]           m_tnew_i,
   input  logic                 w_valid_i,
   input  logic [4:0]           w_wa_i,
   input  logic [1:0]           w_src_i,
   output logic [tmux_size-1:0] sel_o
);

   logic m_hit;
   logic w_hit;

   // Nearest producer wins; an M hit that is not a finished ALU result
   // selects the original value because the stall logic covers that case.
   always_comb begin
      m_hit = (stage_i != STAGE_M) && entry_match(m_valid_i, m_wa_i, reg_i);
      w_hit = entry_match(w_valid_i, w_wa_i, reg_i);
      sel_o = FWD_ORI;
      if (m_hit) begin
         if ((m_tnew_i == 2'd0) && (m_src_i == SRC_ALU)) begin
            sel_o = FWD_EM_ALU;
         end else begin
            sel_o = FWD_ORI;
         end
      end else if (w_hit) begin
         case (w_src_i)
            SRC_ALU, SRC_MEM: sel_o = FWD_MW_ALU;
            SRC_MD:           sel_o = FWD_MW_MD;
            SRC_CP0:          sel_o = FWD_MW_CP0;
            default:          sel_o = FWD_ORI;
         endcase
      end else begin
         sel_o = FWD_ORI;
      end
   end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: hazard and forwarding controller for the 5-stage MIPS pipeline.
//   clk, reset                 clock, async active-high reset
//   D_rs/D_rt, D_tuse_rs/rt    sources of the D instruction and their use stage
//   D_wa, D_tnew, D_src        destination, time-to-ready and result class
//   D_md_op, D_md_use          MD unit start class / HI-LO access
//   flush                      exception/eret flush of D, E, M
//   stall                      freeze PC + D, bubble into E
//   fwd_D_rs .. fwd_M_rt       forwarding mux selects
//   md_busy                    MD unit busy counter is non-zero
// Keeps a shadow scoreboard of E/M/W and the MD busy counter; all outputs
// are combinational from that state plus the D inputs.
module fwd_ctrl
   import fwd_ctrl_pkg::*;
#(
   parameter int TMUX_W   = tmux_size,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        D_rs,
   input  logic [4:0]        D_rt,
   input  logic [1:0]        D_tuse_rs,
   input  logic [1:0]        D_tuse_rt,
   input  logic [4:0]        D_wa,
   input  logic [1:0]        D_tnew,
   input  logic [1:0]        D_src,
   input  logic [1:0]        D_md_op,
   input  logic              D_md_use,
   input  logic              flush,
   output logic              stall,
   output logic [TMUX_W-1:0] fwd_D_rs,
   output logic [TMUX_W-1:0] fwd_D_rt,
   output logic [TMUX_W-1:0] fwd_E_rs,
   output logic [TMUX_W-1:0] fwd_E_rt,
   output logic [TMUX_W-1:0] fwd_M_rt,
   output logic              md_busy
);

   localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   e_entry_t         e_q, e_d;
   m_entry_t         m_q, m_d;
   w_entry_t         w_q, w_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [TMUX_W-1:0] e_rs_pick, e_rt_pick;

   // An operand stalls when its producer in E or M is not ready by the
   // stage that consumes it.
   function automatic logic op_hazard(input logic [4:0] r,
                                      input logic [1:0] tuse,
                                      input e_entry_t   e,
                                      input m_entry_t   m);
      logic e_late;
      logic m_late;
      e_late = entry_match(e.valid, e.wa, r) && (e.tnew > tuse);
      m_late = entry_match(m.valid, m.wa, r) && (m.tnew > tuse);
      return (tuse != TUSE_NONE) && (e_late || m_late);
   endfunction

   assign md_busy = (md_cnt_q != {CNT_W{1'b0}});
   assign stall   = (D_md_use && md_busy)
                  || op_hazard(D_rs, D_tuse_rs, e_q, m_q)
                  || op_hazard(D_rt, D_tuse_rt, e_q, m_q);

   fwd_pick u_pick_d_rs (.reg_i(D_rs), .stage_i(STAGE_D),
      .m_valid_i(m_q.valid), .m_wa_i(m_q.wa), .m_src_i(m_q.src), .m_tnew_i(m_q.tnew),
      .w_valid_i(w_q.valid), .w_wa_i(w_q.wa), .w_src_i(w_q.src), .sel_o(fwd_D_rs));
   fwd_pick u_pick_d_rt (.reg_i(D_rt), .stage_i(STAGE_D),
      .m_valid_i(m_q.valid), .m_wa_i(m_q.wa), .m_src_i(m_q.src), .m_tnew_i(m_q.tnew),
      .w_valid_i(w_q.valid), .w_wa_i(w_q.wa), .w_src_i(w_q.src), .sel_o(fwd_D_rt));
   fwd_pick u_pick_e_rs (.reg_i(e_q.rs), .stage_i(STAGE_E),
      .m_valid_i(m_q.valid), .m_wa_i(m_q.wa), .m_src_i(m_q.src), .m_tnew_i(m_q.tnew),
      .w_valid_i(w_q.valid), .w_wa_i(w_q.wa), .w_src_i(w_q.src), .sel_o(e_rs_pick));
   fwd_pick u_pick_e_rt (.reg_i(e_q.rt), .stage_i(STAGE_E),
      .m_valid_i(m_q.valid), .m_wa_i(m_q.wa), .m_src_i(m_q.src), .m_tnew_i(m_q.tnew),
      .w_valid_i(w_q.valid), .w_wa_i(w_q.wa), .w_src_i(w_q.src), .sel_o(e_rt_pick));
   fwd_pick u_pick_m_rt (.reg_i(m_q.rt), .stage_i(STAGE_M),
      .m_valid_i(m_q.valid), .m_wa_i(m_q.wa), .m_src_i(m_q.src), .m_tnew_i(m_q.tnew),
      .w_valid_i(w_q.valid), .w_wa_i(w_q.wa), .w_src_i(w_q.src), .sel_o(fwd_M_rt));

   // An E operand the instruction never reads keeps the original value.
   assign fwd_E_rs = (e_q.tuse_rs == TUSE_NONE) ? FWD_ORI : e_rs_pick;
   assign fwd_E_rt = (e_q.tuse_rt == TUSE_NONE) ? FWD_ORI : e_rt_pick;

   // Scoreboard advance and MD counter next state; flush beats stall but
   // never aborts an MD operation already in flight.
   always_comb begin
      e_d      = '0;
      m_d      = '0;
      w_d      = '0;
      md_cnt_d = md_cnt_q;
      if (flush) begin
         e_d = '0;
         m_d = '0;
         w_d = '0;
      end else begin
         if (!stall) begin
            e_d.valid   = 1'b1;
            e_d.wa      = D_wa;
            e_d.src     = D_src;
            e_d.tnew    = D_tnew;
            e_d.rs      = D_rs;
            e_d.rt      = D_rt;
            e_d.tuse_rs = D_tuse_rs;
            e_d.tuse_rt = D_tuse_rt;
         end else begin
            e_d = '0;
         end
         m_d.valid = e_q.valid;
         m_d.wa    = e_q.wa;
         m_d.src   = e_q.src;
         m_d.rt    = e_q.rt;
         m_d.tnew  = (e_q.tnew == 2'd0) ? 2'd0 : (e_q.tnew - 2'd1);
         w_d.valid = m_q.valid;
         w_d.wa    = m_q.wa;
         w_d.src   = m_q.src;
      end
      if (!flush && !stall && (D_md_op == MD_MULT)) begin
         md_cnt_d = CNT_W'(MULT_CYC);
      end else if (!flush && !stall && (D_md_op == MD_DIV)) begin
         md_cnt_d = CNT_W'(DIV_CYC);
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end else begin
         md_cnt_d = md_cnt_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q      <= '0;
         m_q      <= '0;
         w_q      <= '0;
         md_cnt_q <= {CNT_W{1'b0}};
      end else begin
         e_q      <= e_d;
         m_q      <= m_d;
         w_q      <= w_d;
         md_cnt_q <= md_cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: a directed prologue followed by random
// instruction streams. The reference model tracks in-flight instructions by
// the cycle they entered E and derives stage/readiness from their age.
module tb_fwd_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
   localparam int NDIR   = 17;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] D_rs, D_rt, D_wa;
   logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew, D_src, D_md_op;
   logic       D_md_use, flush;
   logic       stall, md_busy;
   logic [2:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

   fwd_ctrl dut (
      .clk(clk), .reset(reset),
      .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
      .D_wa(D_wa), .D_tnew(D_tnew), .D_src(D_src), .D_md_op(D_md_op),
      .D_md_use(D_md_use), .flush(flush), .stall(stall),
      .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
      .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] wa, rs, rt;
      int src, tnew, tuse_rs, tuse_rt, md_op;
      bit md_use;
      int enter;
   } inst_t;

   typedef struct packed {
      logic        stall;
      logic        md_busy;
      logic [14:0] sel;
      logic [4:0]  chk;
   } exp_t;

   inst_t pipe[$];
   exp_t  expq[$];
   inst_t d_inst;
   int    cyc, busy_last, idx;
   int    errors, checks;
   bit    held, cur_reset, cur_flush, cur_stall, rst_done;

   // kinds: 0 ALU, 1 load, 2 store, 3 branch, 4 mult, 5 div, 6 mfhi/mflo, 7 mfc0, 8 nop
   int dir_k  [NDIR] = '{0, 0, 0, 1, 3, 1, 2, 8, 4, 6, 0, 7, 0, 0, 0, 5, 6};
   int dir_wa [NDIR] = '{8, 9, 12, 9, 0, 9, 0, 0, 0, 10, 13, 11, 14, 0, 15, 0, 16};
   int dir_rs [NDIR] = '{1, 8, 8, 1, 9, 1, 1, 0, 1, 0, 10, 0, 11, 1, 0, 1, 0};
   int dir_rt [NDIR] = '{2, 8, 0, 0, 0, 0, 9, 0, 2, 0, 10, 0, 1, 2, 0, 2, 0};
   bit dir_fl [NDIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   string sel_name [5] = '{"fwd_D_rs", "fwd_D_rt", "fwd_E_rs", "fwd_E_rt", "fwd_M_rt"};

   function automatic inst_t make_inst(int kind, int wa, int rs, int rt);
      inst_t r;
      r.wa = 5'd0; r.rs = 5'(rs); r.rt = 5'(rt);
      r.src = 0; r.tnew = 0; r.tuse_rs = 3; r.tuse_rt = 3;
      r.md_op = 0; r.md_use = 1'b0; r.enter = 0;
      case (kind)
         0: begin r.wa = 5'(wa); r.tnew = 1; r.tuse_rs = 1; r.tuse_rt = 1; end
         1: begin r.wa = 5'(wa); r.src = 1; r.tnew = 2; r.tuse_rs = 1; end
         2: begin r.tuse_rs = 1; r.tuse_rt = 2; end
         3: begin r.tuse_rs = 0; r.tuse_rt = 0; end
         4: begin r.md_op = 1; r.md_use = 1'b1; r.tuse_rs = 1; r.tuse_rt = 1; end
         5: begin r.md_op = 2; r.md_use = 1'b1; r.tuse_rs = 1; r.tuse_rt = 1; end
         6: begin r.wa = 5'(wa); r.src = 2; r.tnew = 2; r.md_use = 1'b1; end
         7: begin r.wa = 5'(wa); r.src = 3; r.tnew = 2; end
         default: begin r.rs = 5'd0; r.rt = 5'd0; end
      endcase
      return r;
   endfunction

   function automatic bit busy();
      return cyc <= busy_last;
   endfunction

   // Instruction that is 'a' stages past E (0 = E, 1 = M, 2 = W).
   function automatic bit at_age(int a, output inst_t r);
      bit found = 1'b0;
      r = d_inst;
      foreach (pipe[i]) if (cyc - pipe[i].enter == a) begin r = pipe[i]; found = 1'b1; end
      return found;
   endfunction

   function automatic int ready_in(inst_t p, int age);
      return (p.tnew > age) ? p.tnew - age : 0;
   endfunction

   function automatic logic [2:0] pick_ref(logic [4:0] r, int first_age);
      inst_t p;
      for (int a = first_age; a <= 2; a++) begin
         if (at_age(a, p) && r != 5'd0 && p.wa == r) begin
            if (a == 1) return (ready_in(p, 1) == 0 && p.src == 0) ? 3'd1 : 3'd0;
            if (p.src <= 1) return 3'd2;
            if (p.src == 2) return 3'd3;
            return 3'd4;
         end
      end
      return 3'd0;
   endfunction

   function automatic bit op_stall(logic [4:0] r, int tuse);
      inst_t p;
      if (tuse == 3 || r == 5'd0) return 1'b0;
      if (at_age(0, p) && p.wa == r && ready_in(p, 0) > tuse) return 1'b1;
      if (at_age(1, p) && p.wa == r && ready_in(p, 1) > tuse) return 1'b1;
      return 1'b0;
   endfunction

   task automatic compute(output exp_t e);
      inst_t pe, pm;
      bit he, hm;
      he = at_age(0, pe);
      hm = at_age(1, pm);
      e = '0;
      e.md_busy = busy();
      e.stall = (d_inst.md_use && busy()) || op_stall(d_inst.rs, d_inst.tuse_rs)
                || op_stall(d_inst.rt, d_inst.tuse_rt);
      e.sel[2:0] = pick_ref(d_inst.rs, 1); e.chk[0] = (d_inst.tuse_rs != 3);
      e.sel[5:3] = pick_ref(d_inst.rt, 1); e.chk[1] = (d_inst.tuse_rt != 3);
      if (he) begin
         e.sel[8:6]  = pick_ref(pe.rs, 1); e.chk[2] = (pe.tuse_rs != 3);
         e.sel[11:9] = pick_ref(pe.rt, 1); e.chk[3] = (pe.tuse_rt != 3);
      end
      if (hm) begin
         e.sel[14:12] = pick_ref(pm.rt, 2); e.chk[4] = 1'b1;
      end
   endtask

   task automatic advance();
      inst_t n;
      if (cur_reset) begin
         pipe.delete(); busy_last = cyc;
      end else if (cur_flush) begin
         pipe.delete();
      end else if (!cur_stall) begin
         n = d_inst; n.enter = cyc + 1; pipe.push_back(n);
         if (d_inst.md_op == 1) busy_last = cyc + MULT_N;
         else if (d_inst.md_op == 2) busy_last = cyc + DIV_N;
      end
      cyc++;
      while (pipe.size() > 0 && cyc - pipe[0].enter > 2) void'(pipe.pop_front());
   endtask

   task automatic load_next();
      int k;
      if (idx < NDIR) begin
         d_inst = make_inst(dir_k[idx], dir_wa[idx], dir_rs[idx], dir_rt[idx]);
         flush = dir_fl[idx];
         idx++;
      end else begin
         k = $urandom_range(0, 9);
         if (k == 9) k = 0;
         d_inst = make_inst(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         flush = ($urandom_range(0, 24) == 0);
      end
   endtask

   task automatic drive();
      D_rs = d_inst.rs; D_rt = d_inst.rt; D_wa = d_inst.wa;
      D_tuse_rs = 2'(d_inst.tuse_rs); D_tuse_rt = 2'(d_inst.tuse_rt);
      D_tnew = 2'(d_inst.tnew); D_src = 2'(d_inst.src);
      D_md_op = 2'(d_inst.md_op); D_md_use = d_inst.md_use;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents stall/selects/md_busy; compare
   // against the oldest expectation in the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      logic [2:0] act [5];
      if (expq.size() > 0) begin
         e = expq.pop_front();
         act[0] = fwd_D_rs; act[1] = fwd_D_rt; act[2] = fwd_E_rs;
         act[3] = fwd_E_rt; act[4] = fwd_M_rt;
         check("stall", {7'd0, stall}, {7'd0, e.stall});
         check("md_busy", {7'd0, md_busy}, {7'd0, e.md_busy});
         for (int k = 0; k < 5; k++) begin
            if (e.chk[k]) begin
               check(sel_name[k], {5'd0, act[k]}, {5'd0, e.sel[k*3 +: 3]});
            end else begin
               checks++;
               if ($isunknown(act[k]) || act[k] > 3'd4) begin
                  errors++;
                  $display("FAIL %s_range: got %0d expected 0..4", sel_name[k], act[k]);
               end
            end
         end
      end
   end

   initial begin
      exp_t e;
      errors = 0; checks = 0; cyc = 0; busy_last = -1; idx = 0;
      held = 1'b0; rst_done = 1'b0;
      reset = 1'b1; flush = 1'b0;
      d_inst = make_inst(8, 0, 0, 0);
      drive();
      cur_reset = 1'b1; cur_flush = 1'b0; cur_stall = 1'b0;
      for (int it = 0; it < 2400; it++) begin
         @(posedge clk);
         advance();
         #1;
         if (it >= 1) reset = 1'b0;
         if (!rst_done && it > 400 && (busy() || it == 1500)) begin
            rst_done = 1'b1;
            reset = 1'b1;
            #1;
            check("rst_stall", {7'd0, stall}, 8'd0);
            check("rst_md_busy", {7'd0, md_busy}, 8'd0);
            check("rst_fwd_D_rs", {5'd0, fwd_D_rs}, 8'd0);
            check("rst_fwd_D_rt", {5'd0, fwd_D_rt}, 8'd0);
            check("rst_fwd_E_rs", {5'd0, fwd_E_rs}, 8'd0);
            check("rst_fwd_E_rt", {5'd0, fwd_E_rt}, 8'd0);
            check("rst_fwd_M_rt", {5'd0, fwd_M_rt}, 8'd0);
            pipe.delete();
            busy_last = cyc - 1;
            held = 1'b0;
         end
         if (!held) begin
            load_next();
         end else begin
            flush = (idx >= NDIR) && ($urandom_range(0, 24) == 0);
         end
         drive();
         compute(e);
         expq.push_back(e);
         cur_reset = reset; cur_flush = flush; cur_stall = e.stall;
         held = e.stall && !flush && !reset;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
